// File: rtl/fp_sqrt_core_if.sv
// Purpose : request/result bundle between a square-root client and fp_sqrt_core.
// Latency : n/a (wires only).
// Backpressure: none; the client pulses start_i and waits for done_o.
//
// Signals:
//   start_i  request pulse (client -> core)
//   data_i   IEEE-754 single-precision operand (client -> core)
//   data_o   square-root result, sign always 0 (core -> client)
//   opnd_o   operand captured at start, for the downstream sign/NaN stage (core -> client)
//   done_o   one-cycle result-valid pulse (core -> client)
//   busy_o   core is not idle (core -> client)
interface fp_sqrt_core_if;
    logic        start_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [31:0] opnd_o;
    logic        done_o;
    logic        busy_o;

    // Core side.
    modport slave (
        input  start_i,
        input  data_i,
        output data_o,
        output opnd_o,
        output done_o,
        output busy_o
    );

    // Client side.
    modport master (
        output start_i,
        output data_i,
        input  data_o,
        input  opnd_o,
        input  done_o,
        input  busy_o
    );
endinterface

// File: rtl/fp_sqrt_core.sv
// Purpose : single-precision square root of |x|, restoring digit-by-digit, one root bit per cycle.
// Latency : 28 edges for normal operands, 2 edges for zero/denormal/inf/NaN; one result per 29 cycles.
// Backpressure: none; start_i is only sampled in IDLE, requests while busy_o is high are dropped.
//
// Ports:
//   clk    core clock, all state on its rising edge
//   rst_n  asynchronous active-low reset; clears state, outputs and datapath
//   io     fp_sqrt_core_if.slave: start_i/data_i in, data_o/opnd_o/done_o/busy_o out
//
// Build option: define FP_SQRT_ROUND_EN for round-to-nearest-even; otherwise the
// root fraction is truncated. Latency is the same in both builds.
module fp_sqrt_core (
    input  logic           clk,
    input  logic           rst_n,
    fp_sqrt_core_if.slave  io
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [4:0] LAST_ITER = 5'd25;

    logic [1:0]  state_q;
    logic [31:0] opnd_q;      // operand captured at start
    logic [51:0] rad_q;       // radicand, consumed two bits per cycle from the top
    logic [27:0] rem_q;       // partial remainder
    logic [25:0] root_q;      // partial root
    logic [4:0]  cnt_q;       // iteration index 0..25
    logic [31:0] data_o_q;
    logic [31:0] opnd_o_q;

    // ------------------------------------------------------------------
    // Operand classification and radicand setup (on data_i, used in IDLE)
    // ------------------------------------------------------------------
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic        in_special;
    logic [51:0] rad_init;

    always_comb begin
        in_exp     = io.data_i[30:23];
        in_mant    = {1'b1, io.data_i[22:0]};
        in_special = (in_exp == 8'h00) || (in_exp == 8'hFF);
        // An odd biased exponent means an even unbiased one, so the
        // mantissa sits one place lower to keep the root in [2^25, 2^26).
        if (in_exp[0])
            rad_init = {1'b0, in_mant, 27'd0};
        else
            rad_init = {in_mant, 28'd0};
    end

    // ------------------------------------------------------------------
    // One restoring iteration
    // ------------------------------------------------------------------
    logic [27:0] rem_sh;
    logic [27:0] trial;
    logic        take;
    logic [27:0] rem_nx;
    logic [25:0] root_nx;
    logic [51:0] rad_nx;

    always_comb begin
        // Before the last step the remainder is below 2^26, so dropping
        // rem_q[27:26] in the shift loses nothing.
        rem_sh  = {rem_q[25:0], rad_q[51:50]};
        trial   = {root_q, 2'b01};
        take    = (rem_sh >= trial);
        rem_nx  = take ? (rem_sh - trial) : rem_sh;
        root_nx = {root_q[24:0], take};
        rad_nx  = {rad_q[49:0], 2'b00};
    end

    // ------------------------------------------------------------------
    // Result formation (on the captured operand and final root)
    // ------------------------------------------------------------------
    logic [7:0]  op_exp;
    logic [22:0] op_frac;
    logic        op_special;
    logic [31:0] special_res;
    logic [7:0]  exp_half;
    logic [22:0] frac_t;
    logic        guard_b;
    logic        sticky_b;
    logic        round_inc;
    logic [23:0] frac_sum;
    logic [7:0]  exp_r;
    logic [31:0] normal_res;

    always_comb begin
        op_exp     = opnd_q[30:23];
        op_frac    = opnd_q[22:0];
        op_special = (op_exp == 8'h00) || (op_exp == 8'hFF);

        if (op_exp == 8'h00)
            special_res = 32'h0000_0000;                       // zero / flushed denormal
        else if (op_frac == 23'd0)
            special_res = 32'h7F80_0000;                       // infinity
        else
            special_res = {1'b0, 8'hFF, 1'b1, op_frac[21:0]};  // quiet NaN, payload kept

        // (E + 127) >> 1 without a 9-bit intermediate:
        // E = 2k -> k + 63, E = 2k+1 -> k + 64.
        exp_half = {1'b0, op_exp[7:1]} + 8'd63 + {7'd0, op_exp[0]};

        frac_t   = root_q[24:2];
        guard_b  = root_q[1];
        sticky_b = root_q[0] | (rem_q != 28'd0);
    end

`ifdef FP_SQRT_ROUND_EN
    always_comb begin
        round_inc = guard_b & (sticky_b | frac_t[0]);
    end
`else
    logic unused_round;
    always_comb begin
        round_inc    = 1'b0;
        unused_round = guard_b | sticky_b;
    end
`endif

    always_comb begin
        // A carry out of the fraction leaves frac_sum[22:0] at zero and
        // bumps the exponent.
        frac_sum   = {1'b0, frac_t} + {23'd0, round_inc};
        exp_r      = exp_half + {7'd0, frac_sum[23]};
        normal_res = {1'b0, exp_r, frac_sum[22:0]};
    end

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opnd_q   <= 32'd0;
            rad_q    <= 52'd0;
            rem_q    <= 28'd0;
            root_q   <= 26'd0;
            cnt_q    <= 5'd0;
            data_o_q <= 32'd0;
            opnd_o_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.start_i) begin
                        opnd_q <= io.data_i;
                        rem_q  <= 28'd0;
                        root_q <= 26'd0;
                        cnt_q  <= 5'd0;
                        if (in_special) begin
                            state_q <= S_FINISH;
                        end else begin
                            rad_q   <= rad_init;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rad_q  <= rad_nx;
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER)
                        state_q <= S_FINISH;
                end
                S_FINISH: begin
                    data_o_q <= op_special ? special_res : normal_res;
                    opnd_o_q <= opnd_q;
                    state_q  <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign io.data_o = data_o_q;
    assign io.opnd_o = opnd_o_q;
    assign io.done_o = (state_q == S_DONE);
    assign io.busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_sqrt_core.sv
// Purpose : scoreboard bench for fp_sqrt_core with hand-computed square roots.
// Latency : checks 28-edge (normal) and 2-edge (special) start-to-done timing.
// Backpressure: exercises ignored start while busy and reset abort mid-calculation.
module tb_fp_sqrt_core;

    // Edges after the sampling edge until done_o is visible.
    localparam int LAT_NORM = 27;
    localparam int LAT_SPEC = 1;

    // sqrt(5) = 1.1180339887 * 2^1; fraction * 2^23 = 990140.86, so the
    // guard bit is set and rounding lifts 0xF1BBC to 0xF1BBD.
`ifdef FP_SQRT_ROUND_EN
    localparam logic [31:0] SQRT5 = 32'h400F_1BBD;
`else
    localparam logic [31:0] SQRT5 = 32'h400F_1BBC;
`endif

    localparam int NVEC = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp_sqrt_core_if ifc ();

    fp_sqrt_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] opnd;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // sqrt(3) fraction * 2^23 = 6140887.26: guard bit clear, so both
    // builds give 0x3FDDB3D7.
    logic [31:0] v_in [NVEC] = '{
        32'h4080_0000, 32'h4040_0000, 32'h40A0_0000, 32'h7F80_0000,
        32'h7FA0_0001, 32'h0000_0001, 32'hC080_0000, 32'h3F80_0000,
        32'h4180_0000, 32'h3E80_0000, 32'h4010_0000, 32'h8000_0000,
        32'hFF80_0000, 32'h0040_0000, 32'hFFC0_0000, 32'h4000_0000
    };
    logic [31:0] v_res [NVEC] = '{
        32'h4000_0000, 32'h3FDD_B3D7, SQRT5,         32'h7F80_0000,
        32'h7FE0_0001, 32'h0000_0000, 32'h4000_0000, 32'h3F80_0000,
        32'h4080_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'h0000_0000,
        32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h3FB5_04F3
    };
    int v_lat [NVEC] = '{
        LAT_NORM, LAT_NORM, LAT_NORM, LAT_SPEC,
        LAT_SPEC, LAT_SPEC, LAT_NORM, LAT_NORM,
        LAT_NORM, LAT_NORM, LAT_NORM, LAT_SPEC,
        LAT_SPEC, LAT_SPEC, LAT_SPEC, LAT_NORM
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (rst_n && ifc.done_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check32("result",  ifc.data_o, mon_e.res);
                check32("operand", ifc.opnd_o, mon_e.opnd);
                check32("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [31:0] res, input int lat);
        exp_t e;
        @(negedge clk);
        ifc.start_i = 1'b1;
        ifc.data_i  = d;
        e.res       = res;
        e.opnd      = d;
        e.start_cyc = cyc + 1;
        e.lat       = lat;
        sb_q.push_back(e);
        @(negedge clk);
        ifc.start_i = 1'b0;
        ifc.data_i  = ~d;   // must not disturb the captured operand
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        ifc.start_i = 1'b0;
        ifc.data_i  = 32'd0;

        // Asynchronous reset, checked before the first clock edge.
        #1 rst_n = 1'b0;
        #1;
        check32("rst_busy",  {31'd0, ifc.busy_o}, 32'd0);
        check32("rst_done",  {31'd0, ifc.done_o}, 32'd0);
        check32("rst_data",  ifc.data_o, 32'd0);
        check32("rst_opnd",  ifc.opnd_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back to back.
        for (int i = 0; i < NVEC; i++) begin
            issue(v_in[i], v_res[i], v_lat[i]);
            wait_drain();
        end

        // Second start while calculating is dropped.
        issue(32'h4000_0000, 32'h3FB5_04F3, LAT_NORM);
        repeat (3) @(negedge clk);
        check32("busy_calc", {31'd0, ifc.busy_o}, 32'd1);
        ifc.start_i = 1'b1;
        ifc.data_i  = 32'h4180_0000;
        @(negedge clk);
        ifc.start_i = 1'b0;
        wait_drain();

        // Reset mid-calculation aborts with no late done_o.
        issue(32'h4000_0000, 32'h3FB5_04F3, LAT_NORM);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check32("abort_busy", {31'd0, ifc.busy_o}, 32'd0);
        check32("abort_done", {31'd0, ifc.done_o}, 32'd0);
        check32("abort_data", ifc.data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First start after reset release is accepted.
        issue(32'h4080_0000, 32'h4000_0000, LAT_NORM);
        wait_drain();

        // Quiet tail: the monitor flags any stray done_o.
        repeat (40) @(negedge clk);
        check32("idle_busy", {31'd0, ifc.busy_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
